// File: rtl/echo_pkg.sv
// Shared definitions for the ultrasonic echo responder and its sensor driver:
// default timing constants, state encodings and the jitter LFSR step.
package echo_pkg;

  // Default timing at a 50 MHz clock
  localparam int unsigned TRIG_MIN_CYC_DEF = 500;      // 10 us minimum trigger
  localparam int unsigned BURST_CYC_DEF    = 10000;    // 200 us burst
  localparam int unsigned CYC_PER_MM_DEF   = 291;      // round trip at 343 m/s
  localparam int unsigned MAX_MM_DEF       = 4000;     // largest in-range distance
  localparam int unsigned TIMEOUT_CYC_DEF  = 1900000;  // 38 ms out-of-range echo
  localparam int unsigned HOLDOFF_CYC_DEF  = 500;      // dead time after echo

  // Datapath widths
  localparam int unsigned MM_W    = 12;
  localparam int unsigned WIDTH_W = 22;  // holds 4095*291 and the timeout plus jitter

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_BURST   = 3'd2;
  localparam logic [2:0] ST_ECHO    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4)
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/echo_responder_if.sv
// Interfaces of the echo responder:
//   echo_width_if     - request/result bus between the FSM and the width calculator
//   echo_responder_if - sensor-side signal bundle (driver vs responder view)
interface echo_width_if;
  import echo_pkg::*;

  logic               latch;    // capture distance (accepted trigger)
  logic [MM_W-1:0]    dist_mm;  // live distance input
  logic [WIDTH_W-1:0] width;    // echo width for the captured distance

  modport master (output latch, output dist_mm, input  width);
  modport slave  (input  latch, input  dist_mm, output width);
endinterface

interface echo_responder_if;
  logic        trigger_in;
  logic [11:0] dist_mm;
  logic        echo_tx;
  logic        busy;
  logic        trig_err;
  logic [2:0]  state;

  modport driver    (output trigger_in, output dist_mm,
                     input  echo_tx, input busy, input trig_err, input state);
  modport responder (input  trigger_in, input dist_mm,
                     output echo_tx, output busy, output trig_err, output state);
endinterface

// File: rtl/echo_width_calc.sv
// Echo width calculator: captures the distance on an accepted trigger, range
// checks it, multiplies by clocks-per-mm and falls back to the timeout width.
// With ECHO_JITTER_EN defined, adds 0-15 clocks from an 8-bit LFSR that is
// stepped once per accepted trigger.
module echo_width_calc
  import echo_pkg::*;
#(
  parameter int unsigned CYC_PER_MM  = CYC_PER_MM_DEF,
  parameter int unsigned MAX_MM      = MAX_MM_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  echo_width_if.slave  wif
);

  logic [MM_W-1:0]    mm_q, mm_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [WIDTH_W-1:0] prod;
  logic [WIDTH_W-1:0] base;
  logic               in_range;
`ifdef ECHO_JITTER_EN
  logic [7:0]         lfsr_q, lfsr_d;
  logic [3:0]         jit_q, jit_d;
`endif

  // Range check, multiply and optional jitter on the captured distance
  always_comb begin
    mm_d     = wif.latch ? wif.dist_mm : mm_q;
    in_range = (mm_q != '0) && (32'(mm_q) <= MAX_MM);
    prod     = WIDTH_W'(mm_q) * WIDTH_W'(CYC_PER_MM);
    base     = in_range ? prod : WIDTH_W'(TIMEOUT_CYC);
`ifdef ECHO_JITTER_EN
    lfsr_d   = wif.latch ? lfsr8_next(lfsr_q) : lfsr_q;
    jit_d    = wif.latch ? lfsr_q[3:0] : jit_q;
    width_d  = base + WIDTH_W'(jit_q);
`else
    width_d  = base;
`endif
  end

  // Captured distance and registered width; the burst phase covers the latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_q    <= '0;
      width_q <= '0;
`ifdef ECHO_JITTER_EN
      lfsr_q  <= 8'hA5;
      jit_q   <= '0;
`endif
    end else begin
      mm_q    <= mm_d;
      width_q <= width_d;
`ifdef ECHO_JITTER_EN
      lfsr_q  <= lfsr_d;
      jit_q   <= jit_d;
`endif
    end
  end

  assign wif.width = width_q;

endmodule

// File: rtl/echo_responder.sv
// Ultrasonic sensor emulator: synchronizes the trigger, validates its width,
// waits out the burst, then drives an echo pulse whose width encodes dist_mm.
// Optional feature: ECHO_JITTER_EN adds 0-15 clocks of LFSR jitter per echo.
module echo_responder
  import echo_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned CYC_PER_MM   = CYC_PER_MM_DEF,
  parameter int unsigned MAX_MM       = MAX_MM_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        trigger_in,
  input  logic [11:0] dist_mm,
  output logic        echo_tx,
  output logic        busy,
  output logic        trig_err,
  output logic [2:0]  state
);

  logic               sync1_q, sync1_d;
  logic               trig_s_q, trig_s_d;
  logic [1:0]         sync_vld_q, sync_vld_d;
  logic               armed_q, armed_d;
  state_t             state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               echo_q, echo_d;
  logic               err_q, err_d;
  logic               latch;

  echo_width_if wif ();

  assign wif.latch   = latch;
  assign wif.dist_mm = dist_mm;

  echo_width_calc #(
    .CYC_PER_MM  (CYC_PER_MM),
    .MAX_MM      (MAX_MM),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_width_calc (
    .clk (clk_50M),
    .rst (reset),
    .wif (wif)
  );

  // Two-flop trigger synchronizer; sync_vld marks when trig_s carries real
  // samples after reset, so a trigger held through reset is never mistaken
  // for a fresh low level.
  always_comb begin
    sync1_d    = trigger_in;
    trig_s_d   = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
  end

  // Trigger validation, burst delay, echo timing and holdoff sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    echo_d  = echo_q;
    err_d   = 1'b0;
    armed_d = armed_q;
    latch   = 1'b0;
    cnt_inc = cnt_q + 1'b1;

    if (state_q == ST_IDLE && sync_vld_q[1] && !trig_s_q)
      armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && trig_s_q) begin
          state_d = ST_TRIG;
          cnt_d   = WIDTH_W'(1);
        end
      end
      ST_TRIG: begin
        if (trig_s_q) begin
          if (cnt_q < WIDTH_W'(TRIG_MIN_CYC))
            cnt_d = cnt_inc;
        end else if (cnt_q >= WIDTH_W'(TRIG_MIN_CYC)) begin
          state_d = ST_BURST;
          cnt_d   = '0;
          latch   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_inc >= WIDTH_W'(BURST_CYC)) begin
          state_d = ST_ECHO;
          cnt_d   = '0;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ECHO: begin
        if (cnt_inc >= wif.width) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          echo_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLDOFF: begin
        // Dead time elapsed: leave only once the trigger line is idle
        if (cnt_inc >= WIDTH_W'(HOLDOFF_CYC)) begin
          if (!trig_s_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
  end

  // State, counter, synchronizer and output registers
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      sync_vld_q <= '0;
      armed_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      echo_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      trig_s_q   <= trig_s_d;
      sync_vld_q <= sync_vld_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_q     <= echo_d;
      err_q      <= err_d;
    end
  end

  assign echo_tx  = echo_q;
  assign trig_err = err_q;
  assign state    = state_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_echo_responder.sv
// Testbench for echo_responder with shortened timing parameters.
// Expected timing and widths come from a distance-to-width reference model.
module tb_echo_responder;

  localparam int T_TRIG = 20;
  localparam int T_BURST = 30;
  localparam int T_CPM = 3;
  localparam int T_MAX = 1200;
  localparam int T_TMO = 4000;
  localparam int T_HOLD = 10;
`ifdef ECHO_JITTER_EN
  localparam int T_JIT = 15;
`else
  localparam int T_JIT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_width = 0;

  echo_responder_if bus ();

  echo_responder #(
    .TRIG_MIN_CYC (T_TRIG),
    .BURST_CYC    (T_BURST),
    .CYC_PER_MM   (T_CPM),
    .MAX_MM       (T_MAX),
    .TIMEOUT_CYC  (T_TMO),
    .HOLDOFF_CYC  (T_HOLD)
  ) dut (
    .clk_50M    (clk),
    .reset      (rst),
    .trigger_in (bus.trigger_in),
    .dist_mm    (bus.dist_mm),
    .echo_tx    (bus.echo_tx),
    .busy       (bus.busy),
    .trig_err   (bus.trig_err),
    .state      (bus.state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: echo width for a captured distance
  function automatic int exp_width(input int mm);
    if (mm >= 1 && mm <= T_MAX) return mm * T_CPM;
    return T_TMO;
  endfunction

  // One trigger of trig_len clocks at distance mm; optionally re-pulse the
  // trigger during the echo. Checks error pulse or full echo timing.
  task automatic run_trigger(input int trig_len, input int mm, input bit retrig);
    int t0, t_rise, t_fall, k, errs, err_at, lo;
    bit echo_seen;
    errs = 0; err_at = -1; echo_seen = 1'b0;
    bus.dist_mm = 12'(mm);
    bus.trigger_in = 1'b1;
    repeat (trig_len) tick();
    bus.trigger_in = 1'b0;
    tick();
    t0 = cyc;
    if (trig_len < T_TRIG) begin
      repeat (10) begin
        tick();
        if (bus.trig_err === 1'b1) begin errs++; err_at = cyc - t0; end
        if (bus.echo_tx === 1'b1) echo_seen = 1'b1;
      end
      check("short_err_pulses", errs, 1);
      check("short_err_time", err_at, 2);
      check("short_no_echo", int'(echo_seen), 0);
      check("short_state", int'(bus.state), 0);
      return;
    end
    tick(); tick();
    bus.dist_mm = ~12'(mm);
    k = 0;
    while (bus.echo_tx !== 1'b1 && k < T_BURST + 20) begin
      tick(); k++;
      if (bus.trig_err === 1'b1) errs++;
    end
    if (bus.echo_tx !== 1'b1) begin
      check("rise_timeout", 0, 1);
      return;
    end
    check("rise_delay", cyc - t0, 2 + T_BURST);
    t_rise = cyc;
    k = 0;
    while (bus.echo_tx === 1'b1 && k < T_TMO + T_JIT + 20) begin
      bus.trigger_in = retrig && (k >= 3) && (k < 3 + T_TRIG + 5);
      tick(); k++;
      if (bus.trig_err === 1'b1) errs++;
    end
    bus.trigger_in = 1'b0;
    t_fall = cyc;
    last_width = t_fall - t_rise;
    lo = exp_width(mm);
    check_rng("echo_width", last_width, lo, lo + T_JIT);
    k = 0;
    while (bus.busy === 1'b1 && k < T_HOLD + 20) begin
      tick(); k++;
      if (bus.trig_err === 1'b1) errs++;
    end
    check("holdoff", cyc - t_fall, T_HOLD);
    check("no_err_while_busy", errs, 0);
    check("idle_state", int'(bus.state), 0);
  endtask

  initial begin
    int wmin, wmax, k;
    bit seen;
    bus.trigger_in = 1'b0;
    bus.dist_mm = 12'd0;

    // Reset state
    repeat (3) tick();
    check("rst_echo", int'(bus.echo_tx), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_err", int'(bus.trig_err), 0);
    check("rst_state", int'(bus.state), 0);
    rst = 1'b0;
    repeat (5) tick();

    // Main function, minimum-width boundary and too-short trigger
    run_trigger(25, 100, 1'b0);
    run_trigger(T_TRIG - 1, 100, 1'b0);
    run_trigger(T_TRIG, 50, 1'b0);

    // Distance range boundaries
    run_trigger(25, 0, 1'b0);
    run_trigger(25, 1, 1'b0);
    run_trigger(25, T_MAX, 1'b0);
    run_trigger(25, T_MAX + 1, 1'b0);
    run_trigger(25, 4095, 1'b0);

    // Retrigger during echo with distance changed after the latch
    run_trigger(25, 200, 1'b1);

    // Randomized triggers against the reference model
    for (int i = 0; i < 8; i++)
      run_trigger(int'($urandom_range(10, 40)), int'($urandom_range(0, 1300)), 1'($urandom_range(0, 1)));

    // Repeated short-distance echoes (jitter spread when enabled)
    wmin = 1 << 30; wmax = 0;
    for (int i = 0; i < 20; i++) begin
      run_trigger(25, 10, 1'b0);
      if (last_width < wmin) wmin = last_width;
      if (last_width > wmax) wmax = last_width;
    end
`ifdef ECHO_JITTER_EN
    check("jitter_varies", int'(wmax > wmin), 1);
`else
    check("width_constant", wmax - wmin, 0);
`endif

    // Reset asserted mid-echo, trigger held high through release
    bus.dist_mm = 12'd500;
    bus.trigger_in = 1'b1;
    repeat (25) tick();
    bus.trigger_in = 1'b0;
    k = 0;
    while (bus.echo_tx !== 1'b1 && k < T_BURST + 20) begin tick(); k++; end
    repeat (50) tick();
    check("mid_echo_high", int'(bus.echo_tx), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_echo", int'(bus.echo_tx), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_state", int'(bus.state), 0);
    bus.trigger_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (bus.echo_tx === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    check("held_trig_ignored", int'(seen), 0);
    bus.trigger_in = 1'b0;
    repeat (5) tick();
    run_trigger(25, 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/echo_responder.md
ECHO_RESPONDER -- requirements
Module: echo_responder

Interface
REQ-001 SHALL have parameter TRIG_MIN_CYC, default 500, minimum valid trigger high width in clocks (10 us at 50 MHz).
REQ-002 SHALL have parameter BURST_CYC, default 10000, delay from trigger fall to echo rise (200 us burst).
REQ-003 SHALL have parameter CYC_PER_MM, default 291, echo clocks per millimetre of distance (round trip at 343 m/s).
REQ-004 SHALL have parameter MAX_MM, default 4000, largest in-range distance.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1900000, echo width for out-of-range distance (38 ms).
REQ-006 SHALL have parameter HOLDOFF_CYC, default 500, dead time after echo fall.
REQ-007 SHALL have port clk_50M, input, 1, sole clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port trigger_in, input, 1, asynchronous trigger from the sensor driver.
REQ-010 SHALL have port dist_mm, input, 12, distance the block emulates.
REQ-011 SHALL have port echo_tx, output, 1, registered echo pulse.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port trig_err, output, 1, one-clock pulse when a trigger was too short.
REQ-014 SHALL have port state, output, 3, current FSM state encoding.

Function
REQ-015 SHALL pass trigger_in through a 2-flop synchronizer (trig_s); the FSM SHALL use only trig_s.
REQ-016 SHALL have states IDLE=0, TRIG=1, BURST=2, ECHO=3, HOLDOFF=4; codes 5-7 SHALL return to IDLE.
REQ-017 IDLE: on trig_s high, go to TRIG with the width counter at 1; otherwise stay.
REQ-018 TRIG: count clocks while trig_s is high, saturating at TRIG_MIN_CYC.
REQ-019 TRIG: on trig_s low with count >= TRIG_MIN_CYC, go to BURST; latch dist_mm on this same edge.
REQ-020 TRIG: on trig_s low with count < TRIG_MIN_CYC, go to IDLE and pulse trig_err for one clock.
REQ-021 BURST: after BURST_CYC clocks, go to ECHO; echo_tx SHALL rise exactly 2+BURST_CYC clocks after the edge at which trigger_in is first sampled low.
REQ-022 ECHO: echo width SHALL be latched_mm*CYC_PER_MM clocks when 1 <= latched_mm <= MAX_MM, and TIMEOUT_CYC otherwise (including 0); use a 22-bit product/counter with no overflow.
REQ-023 ECHO: at end of width, drive echo_tx low and go to HOLDOFF.
REQ-024 HOLDOFF: after HOLDOFF_CYC clocks, go to IDLE only when trig_s is low; otherwise wait in HOLDOFF.
REQ-025 SHALL ignore trig_s activity in BURST, ECHO and HOLDOFF (no retrigger, no trig_err).
REQ-026 SHALL ignore dist_mm changes after the latch until the next valid trigger.

Reset
REQ-027 SHALL, on reset assertion, immediately set echo_tx=0, busy=0, trig_err=0, state=IDLE, and clear counters, latched distance and synchronizer, including mid-echo.
REQ-028 SHALL, after reset release, require trig_s to be seen low in IDLE before a new TRIG (no trigger held high through reset is accepted).

Configuration
REQ-029 SHALL, with ECHO_JITTER_EN defined, add 0-15 clocks to every echo width taken from the low 4 bits of an 8-bit maximal LFSR (seed 0xA5 at reset) stepped once per accepted trigger.
REQ-030 SHALL, without ECHO_JITTER_EN, produce echo widths exactly per REQ-022 and contain no LFSR.

Structure
REQ-031 SHALL have a shared package echo_pkg holding the state enum/encodings and the default timing constants shared with the sensor driver.
REQ-032 SHALL have the width computation (range check, multiply, optional jitter) in one sub-module echo_width_calc; synchronizer and FSM stay in echo_responder.

Verification (ECHO_JITTER_EN undefined unless stated)
REQ-033 dist_mm=100, trigger 600 clocks -> echo_tx high after 2+10000 clocks for exactly 29100 clocks, then busy low after 500 more.
REQ-034 trigger 499 clocks -> trig_err one-clock pulse, echo_tx stays 0, state returns 0.
REQ-035 dist_mm=0 and dist_mm=4001 -> echo width 1900000 clocks each; dist_mm=4000 -> 1164000.
REQ-036 second trigger during ECHO, and dist_mm changed after latch -> no effect on current echo width.
REQ-037 reset asserted mid-ECHO -> echo_tx low without a clock edge; trigger held high through release -> no echo until it goes low and high again.
REQ-038 ECHO_JITTER_EN, dist_mm=10, 20 triggers -> every width in 2910..2925, not all equal.
